// File: rtl/operand_fetch.sv
// Operand fetch sequencer: reads rs/rt from the register file, bypasses
// racing writebacks and hands operands to execute over valid/ready.
module operand_fetch #(
    parameter int unsigned num_regs  = 12,
    parameter int unsigned reg_width = 8,
    localparam int unsigned AW       = $clog2(num_regs)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [AW-1:0]        dec_rs_addr,
    input  logic [AW-1:0]        dec_rt_addr,
    input  logic [AW-1:0]        dec_rd_addr,
    input  logic                 dec_wen,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_addr,
    input  logic [reg_width-1:0] wb_data,
    output logic                 rf_read,
    output logic [AW-1:0]        rf_rs_addr,
    output logic [AW-1:0]        rf_rt_addr,
    input  logic [reg_width-1:0] rf_rs_data,
    input  logic [reg_width-1:0] rf_rt_data,
    output logic                 rf_write,
    output logic [AW-1:0]        rf_rd_addr,
    output logic [reg_width-1:0] rf_rd_in,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [reg_width-1:0] ex_rs_data,
    output logic [reg_width-1:0] ex_rt_data,
    output logic [AW-1:0]        ex_rd_addr,
    output logic                 ex_wen
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;

    state_t               state;
    logic [AW-1:0]        rs_q;
    logic [AW-1:0]        rt_q;
    logic [AW-1:0]        rd_q;
    logic                 wen_q;
    logic                 byp_rs;
    logic                 byp_rt;
    logic [reg_width-1:0] byp_rs_val;
    logic [reg_width-1:0] byp_rt_val;

    logic wb_ok;
    logic rs_ok;
    logic rt_ok;
    logic rs_hit;
    logic rt_hit;
    logic take;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < num_regs;
    endfunction

    assign wb_ok  = wb_valid && in_range(wb_addr);
    assign rs_ok  = in_range(rs_q);
    assign rt_ok  = in_range(rt_q);
    assign rs_hit = wb_ok && (wb_addr == rs_q);
    assign rt_hit = wb_ok && (wb_addr == rt_q);

    assign dec_ready = rst_n &&
                       ((state == IDLE) || ((state == OUT) && ex_ready));
    assign take      = dec_valid && dec_ready;

    assign rf_rs_addr = rs_q;
    assign rf_rt_addr = rt_q;

    // Writeback path bypasses the FSM entirely.
    assign rf_write   = wb_ok && rst_n;
    assign rf_rd_addr = wb_addr;
    assign rf_rd_in   = wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            byp_rs     <= 1'b0;
            byp_rt     <= 1'b0;
            byp_rs_val <= '0;
            byp_rt_val <= '0;
            rf_read    <= 1'b0;
            ex_valid   <= 1'b0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_rd_addr <= '0;
            ex_wen     <= 1'b0;
        end else begin
            rf_read <= take;
            if (take) begin
                rs_q  <= dec_rs_addr;
                rt_q  <= dec_rt_addr;
                rd_q  <= dec_rd_addr;
                wen_q <= dec_wen;
            end
            unique case (state)
                IDLE: begin
                    if (take) state <= ISSUE;
                end
                ISSUE: begin
                    byp_rs     <= rs_hit;
                    byp_rt     <= rt_hit;
                    byp_rs_val <= wb_data;
                    byp_rt_val <= wb_data;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    // Live wb beats the ISSUE bypass, which beats the RF.
                    if (!rs_ok)      ex_rs_data <= '0;
                    else if (rs_hit) ex_rs_data <= wb_data;
                    else if (byp_rs) ex_rs_data <= byp_rs_val;
                    else             ex_rs_data <= rf_rs_data;
                    if (!rt_ok)      ex_rt_data <= '0;
                    else if (rt_hit) ex_rt_data <= wb_data;
                    else if (byp_rt) ex_rt_data <= byp_rt_val;
                    else             ex_rt_data <= rf_rt_data;
                    ex_rd_addr <= rd_q;
                    ex_wen     <= wen_q;
                    ex_valid   <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (ex_ready) begin
                        ex_valid <= 1'b0;
                        state    <= take ? ISSUE : IDLE;
                    end else begin
                        if (rs_hit) ex_rs_data <= wb_data;
                        if (rt_hit) ex_rt_data <= wb_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dec_valid;
    logic          dec_ready;
    logic [AW-1:0] dec_rs_addr;
    logic [AW-1:0] dec_rt_addr;
    logic [AW-1:0] dec_rd_addr;
    logic          dec_wen;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [7:0]    wb_data;
    logic          rf_read;
    logic [AW-1:0] rf_rs_addr;
    logic [AW-1:0] rf_rt_addr;
    logic [7:0]    rf_rs_data;
    logic [7:0]    rf_rt_data;
    logic          rf_write;
    logic [AW-1:0] rf_rd_addr;
    logic [7:0]    rf_rd_in;
    logic          ex_valid;
    logic          ex_ready;
    logic [7:0]    ex_rs_data;
    logic [7:0]    ex_rt_data;
    logic [AW-1:0] ex_rd_addr;
    logic          ex_wen;

    typedef struct packed {
        logic [7:0]    rs;
        logic [7:0]    rt;
        logic [AW-1:0] rd;
        logic          wen;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    operand_fetch #(.num_regs(12), .reg_width(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
        .dec_rd_addr(dec_rd_addr), .dec_wen(dec_wen),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_read(rf_read), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .rf_write(rf_write), .rf_rd_addr(rf_rd_addr), .rf_rd_in(rf_rd_in),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_rd_addr(ex_rd_addr), .ex_wen(ex_wen)
    );

    always #5 clk = ~clk;

    // Register file: registered read returns pre-write contents.
    logic [7:0] rf [12];
    always @(posedge clk) begin
        if (rf_write && rf_rd_addr < 12) rf[rf_rd_addr] <= rf_rd_in;
        if (rf_read) begin
            rf_rs_data <= (rf_rs_addr < 12) ? rf[rf_rs_addr] : 8'h00;
            rf_rt_data <= (rf_rt_addr < 12) ? rf[rf_rt_addr] : 8'h00;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ex_valid && ex_ready) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got %h%h, none expected",
                         ex_rs_data, ex_rt_data);
            end else begin
                e = sbq.pop_front();
                if ({ex_rs_data, ex_rt_data, ex_rd_addr, ex_wen} !== e) begin
                    miscompares++;
                    $display("FAIL ex_out: got rs=%h rt=%h rd=%0d wen=%b, expected rs=%h rt=%h rd=%0d wen=%b",
                             ex_rs_data, ex_rt_data, ex_rd_addr, ex_wen,
                             e.rs, e.rt, e.rd, e.wen);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [7:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] rs, input logic [7:0] rt,
                        input logic [AW-1:0] rd, input logic wen);
        exp_t e;
        e.rs = rs;
        e.rt = rt;
        e.rd = rd;
        e.wen = wen;
        sbq.push_back(e);
    endtask

    // Returns just after the accepting edge, i.e. in the ISSUE cycle.
    task automatic accept(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] rd, input logic wen);
        bit ok = 0;
        dec_valid   = 1'b1;
        dec_rs_addr = rs;
        dec_rt_addr = rt;
        dec_rd_addr = rd;
        dec_wen     = wen;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (dec_ready) ok = 1;
        end
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && sbq.size() != 0; i++) tick();
        check(name, sbq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        dec_valid = 1'b0;
        dec_rs_addr = '0;
        dec_rt_addr = '0;
        dec_rd_addr = '0;
        dec_wen = 1'b0;
        wb_valid = 1'b1;
        wb_addr = 4'd3;
        wb_data = 8'h99;
        ex_ready = 1'b1;
        repeat (2) tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_dec_ready", dec_ready, 0);
        check("rst_rf_read", rf_read, 0);
        check("rst_rf_write", rf_write, 0);
        check("rst_ex_data", {ex_rs_data, ex_rt_data, ex_rd_addr, ex_wen}, 0);
        wb_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_dec_ready", dec_ready, 1);

        // Basic fetch with latency check
        wb(4'd0, 8'h00);
        wb_valid = 1'b1;
        wb_addr = 4'd3;
        wb_data = 8'h5A;
        #1;
        check("wb_rf_write", rf_write, 1);
        check("wb_rf_addr", rf_rd_addr, 3);
        tick();
        wb_valid = 1'b0;
        push(8'h5A, 8'h00, 4'd7, 1'b1);
        accept(4'd3, 4'd0, 4'd7, 1'b1);
        check("t1_rf_read", rf_read, 1);
        check("t1_rf_rs_addr", rf_rs_addr, 3);
        tick();
        check("t1_capture_valid", ex_valid, 0);
        tick();
        check("t1_out_valid", ex_valid, 1);
        drain("t1_drain");

        // ISSUE-cycle race, rs == rt
        wb(4'd4, 8'h11);
        push(8'h22, 8'h22, 4'd1, 1'b0);
        accept(4'd4, 4'd4, 4'd1, 1'b0);
        wb(4'd4, 8'h22);
        drain("t2_drain");
        push(8'h22, 8'h00, 4'd2, 1'b1);
        accept(4'd4, 4'd0, 4'd2, 1'b1);
        drain("t2b_drain");

        // CAPTURE wb overrides ISSUE bypass
        push(8'h44, 8'h00, 4'd5, 1'b1);
        accept(4'd5, 4'd0, 4'd5, 1'b1);
        wb(4'd5, 8'h33);
        wb(4'd5, 8'h44);
        drain("t3_drain");

        // Backpressure with in-place update
        wb(4'd6, 8'h10);
        ex_ready = 1'b0;
        push(8'h5A, 8'h7E, 4'd8, 1'b1);
        accept(4'd3, 4'd6, 4'd8, 1'b1);
        tick();
        tick();
        check("t4_valid", ex_valid, 1);
        check("t4_rt_before", ex_rt_data, 8'h10);
        wb(4'd6, 8'h7E);
        check("t4_rt_updated", ex_rt_data, 8'h7E);
        check("t4_rs_held", ex_rs_data, 8'h5A);
        dec_valid = 1'b1;
        dec_rs_addr = 4'd6;
        dec_rt_addr = 4'd3;
        dec_rd_addr = 4'd2;
        dec_wen = 1'b0;
        #1;
        check("t4_dec_ready_low", dec_ready, 0);
        tick();
        tick();
        check("t4_valid_hold", ex_valid, 1);
        check("t4_dec_ready_hold", dec_ready, 0);
        push(8'h7E, 8'h5A, 4'd2, 1'b0);
        ex_ready = 1'b1;
        #1;
        check("t4_dec_ready_release", dec_ready, 1);
        tick();
        dec_valid = 1'b0;
        check("t4_direct_issue", rf_read, 1);
        drain("t4_drain");

        // Out-of-range read and writeback
        push(8'h00, 8'h5A, 4'd3, 1'b0);
        accept(4'd13, 4'd3, 4'd3, 1'b0);
        wb_valid = 1'b1;
        wb_addr = 4'd13;
        wb_data = 8'hEE;
        #1;
        check("t5_rf_write_13", rf_write, 0);
        tick();
        wb_addr = 4'd14;
        wb_data = 8'hFF;
        #1;
        check("t5_rf_write_14", rf_write, 0);
        tick();
        wb_valid = 1'b0;
        drain("t5_drain");

        // Reset during CAPTURE
        accept(4'd3, 4'd4, 4'd9, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_ex_valid", ex_valid, 0);
        check("t6_ex_data", {ex_rs_data, ex_rt_data, ex_rd_addr, ex_wen}, 0);
        check("t6_rf_read", rf_read, 0);
        check("t6_dec_ready", dec_ready, 0);
        tick();
        rst_n = 1'b1;
        push(8'h5A, 8'h22, 4'd9, 1'b1);
        accept(4'd3, 4'd4, 4'd9, 1'b1);
        check("t6_rf_read_after", rf_read, 1);
        tick();
        check("t6_capture_valid", ex_valid, 0);
        tick();
        check("t6_out_valid", ex_valid, 1);
        drain("t6_drain");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
